// File: rtl/top_sram_pkg.sv
// Shared types and sizes for the SRAM exerciser: controller state encoding and bus widths.
`timescale 1ns/1ps
package top_sram_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 256;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    R_SETUP,
    R_HOLD,
    DONE
  } state_t;

  function automatic logic [DATA_W-1:0] wr_pattern(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] x);
    return a[DATA_W-1:0] ^ x;
  endfunction

endpackage

// File: rtl/sram_256x4.sv
// 256x4 SRAM model: write on rising clk when cs&we, combinational tristated read when cs&oe&~we.
`timescale 1ns/1ps
module sram_256x4
  import top_sram_pkg::*;
(
  input  logic              clk,
  input  logic              cs,
  input  logic              we,
  input  logic              oe,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_rd_en;

  assign w_rd_en = cs & oe & ~we;
  assign data    = w_rd_en ? r_mem[address] : {DATA_W{1'bz}};

  // Contents deliberately survive reset, so there is no reset term here.
  always_ff @(posedge clk) begin
    if (cs && we) begin
      r_mem[address] <= data;
    end
  end

endmodule

// File: rtl/top_sram.sv
// SRAM exerciser: fills NUM_WORDS words with address^PATTERN_XOR, then reads them all back, then parks in DONE.
`timescale 1ns/1ps
module top_sram
  import top_sram_pkg::*;
#(
  parameter int                NUM_WORDS   = 32,
  parameter logic [DATA_W-1:0] PATTERN_XOR = 4'hA
) (
  input  logic              clk,
  input  logic              reset,
  output logic              cs,
  output logic              we,
  output logic              oe,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_cs;
  logic              r_we;
  logic              r_oe;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdat;
  logic              r_drv;
  logic [ADDR_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 8'd1;

  assign cs      = r_cs;
  assign we      = r_we;
  assign oe      = r_oe;
  assign address = r_addr;
  assign data    = r_drv ? r_wdat : {DATA_W{1'bz}};

  // Outputs are set on the edge entering each state, so they are valid for the whole state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
      r_oe    <= 1'b0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_drv   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= W_SETUP;
          r_cs    <= 1'b1;
          r_we    <= 1'b0;
          r_oe    <= 1'b0;
          r_addr  <= r_cnt;
          r_wdat  <= wr_pattern(r_cnt, PATTERN_XOR);
          r_drv   <= 1'b1;
        end
        W_SETUP: begin
          r_state <= W_PULSE;
          r_we    <= 1'b1;
        end
        W_PULSE: begin
          r_we <= 1'b0;
          if (r_cnt == LAST) begin
            // Drive release and oe rise on the same edge, so the bus never sees two drivers.
            r_state <= R_SETUP;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_oe    <= 1'b1;
            r_drv   <= 1'b0;
          end else begin
            r_state <= W_SETUP;
            r_cnt   <= w_cnt_inc;
            r_addr  <= w_cnt_inc;
            r_wdat  <= wr_pattern(w_cnt_inc, PATTERN_XOR);
          end
        end
        R_SETUP: begin
          r_state <= R_HOLD;
        end
        R_HOLD: begin
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_cs    <= 1'b0;
            r_oe    <= 1'b0;
          end else begin
            r_state <= R_SETUP;
            r_cnt   <= w_cnt_inc;
            r_addr  <= w_cnt_inc;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_oe    <= 1'b0;
          r_drv   <= 1'b0;
        end
      endcase
    end
  end

  sram_256x4 u_sram (
    .clk     (clk),
    .cs      (r_cs),
    .we      (r_we),
    .oe      (r_oe),
    .address (r_addr),
    .data    (data)
  );

endmodule

// File: tb/tb_top_sram.sv
// Directed bench for top_sram: per-cycle bus expectations across full runs, resets after DONE and mid-read.
`timescale 1ns/1ps
module tb_top_sram;
  import top_sram_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  wire        cs;
  wire        we;
  wire        oe;
  wire  [7:0] address;
  wire  [3:0] data;

  int n_tests = 0;
  int n_fail  = 0;

  top_sram dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .we      (we),
    .oe      (oe),
    .address (address),
    .data    (data)
  );

  always #1 clk = ~clk;

  typedef struct {
    int         k;
    logic [7:0] a;
    logic [3:0] d;
    logic       w;
    logic       o;
  } spot_t;

  // Hand-computed spot vectors: cycle index after reset release -> bus contents.
  spot_t spots [6] = '{
    '{1,   8'h00, 4'hA, 1'b0, 1'b0},
    '{2,   8'h00, 4'hA, 1'b1, 1'b0},
    '{64,  8'h1F, 4'h5, 1'b1, 1'b0},
    '{65,  8'h00, 4'hA, 1'b0, 1'b1},
    '{75,  8'h05, 4'hF, 1'b0, 1'b1},
    '{128, 8'h1F, 4'h5, 1'b0, 1'b1}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, " cs"},   32'(cs),        32'd0);
    check({tag, " we"},   32'(we),        32'd0);
    check({tag, " oe"},   32'(oe),        32'd0);
    check({tag, " addr"}, 32'(address),   32'd0);
    check({tag, " drv"},  32'(dut.r_drv), 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #0.5;
    check_idle_bus({tag, " in-reset"});
    @(negedge clk);
    @(negedge clk);
    check_idle_bus({tag, " end-reset"});
    reset = 1'b0;
  endtask

  task automatic run_seq(input int last_k, input string run);
    logic       e_cs, e_we, e_oe, e_drv, e_dvld;
    logic [7:0] e_a;
    logic [3:0] e_d;
    check({run, " idle state"}, 32'(dut.r_state), 32'(IDLE));
    check({run, " idle cs"},    32'(cs),          32'd0);
    for (int k = 1; k <= last_k; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 64) begin
        e_a = 8'((k - 1) / 2); e_cs = 1'b1; e_we = ((k - 1) % 2) == 1; e_oe = 1'b0;
        e_drv = 1'b1; e_dvld = 1'b1;
      end else if (k <= 128) begin
        e_a = 8'((k - 65) / 2); e_cs = 1'b1; e_we = 1'b0; e_oe = 1'b1;
        e_drv = 1'b0; e_dvld = 1'b1;
      end else begin
        e_a = 8'h1F; e_cs = 1'b0; e_we = 1'b0; e_oe = 1'b0;
        e_drv = 1'b0; e_dvld = 1'b0;
      end
      e_d = e_a[3:0] ^ 4'hA;
      check($sformatf("%s k%0d cs", run, k),   32'(cs),        32'(e_cs));
      check($sformatf("%s k%0d we", run, k),   32'(we),        32'(e_we));
      check($sformatf("%s k%0d oe", run, k),   32'(oe),        32'(e_oe));
      check($sformatf("%s k%0d addr", run, k), 32'(address),   32'(e_a));
      check($sformatf("%s k%0d drv", run, k),  32'(dut.r_drv), 32'(e_drv));
      if (e_dvld)
        check($sformatf("%s k%0d data", run, k), 32'(data), 32'(e_d));
      if (k == 129)
        check($sformatf("%s k%0d done", run, k), 32'(dut.r_state), 32'(DONE));
      foreach (spots[i]) begin
        if (spots[i].k == k) begin
          check($sformatf("%s spot%0d addr", run, i), 32'(address), 32'(spots[i].a));
          check($sformatf("%s spot%0d data", run, i), 32'(data),    32'(spots[i].d));
          check($sformatf("%s spot%0d we", run, i),   32'(we),      32'(spots[i].w));
          check($sformatf("%s spot%0d oe", run, i),   32'(oe),      32'(spots[i].o));
        end
      end
    end
  endtask

  initial begin
    apply_reset("rst1");
    run_seq(150, "run1");
    apply_reset("rst2");
    run_seq(150, "run2");
    apply_reset("rst3");
    // Stop on R_SETUP of address 0x10, then reset in the middle of the read phase.
    run_seq(97, "run3");
    check("run3 mid addr", 32'(address), 32'h10);
    apply_reset("rst4");
    run_seq(150, "run4");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
